// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the single data-memory port between the I-cache
// (read-only) and the D-cache (read/write); one block transfer at a time.
module mem_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_READ,
  input  logic [ADDR_W-1:0] I_ADDRESS,
  output logic [DATA_W-1:0] I_READDATA,
  output logic              I_BUSYWAIT,
  input  logic              D_READ,
  input  logic              D_WRITE,
  input  logic [ADDR_W-1:0] D_ADDRESS,
  input  logic [DATA_W-1:0] D_WRITEDATA,
  output logic [DATA_W-1:0] D_READDATA,
  output logic              D_BUSYWAIT,
  output logic              M_READ,
  output logic              M_WRITE,
  output logic [ADDR_W-1:0] M_ADDRESS,
  output logic [DATA_W-1:0] M_WRITEDATA,
  input  logic [DATA_W-1:0] M_READDATA,
  input  logic              M_BUSYWAIT
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} state_t;

  state_t            state_q;
  logic              grant_q;      // 1 = D side owns the memory port
  logic              last_q;       // side served most recently, 1 = D
  logic              seen_busy_q;
  logic              d_wr_q;
  logic [7:0]        serve_cnt_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  logic i_req;
  logic d_req;
  logic grant_d;

  assign i_req   = I_READ;
  assign d_req   = D_READ | D_WRITE;
  assign grant_d = (i_req & d_req) ? ~last_q : d_req;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      last_q      <= 1'b0;
      seen_busy_q <= 1'b0;
      d_wr_q      <= 1'b0;
      serve_cnt_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_req | d_req) begin
            state_q     <= grant_d ? SERVE_D : SERVE_I;
            grant_q     <= grant_d;
            d_wr_q      <= D_WRITE;
            serve_cnt_q <= '0;
          end
        end
        SERVE_I, SERVE_D: begin
          if (serve_cnt_q != 8'hFF) serve_cnt_q <= serve_cnt_q + 8'd1;
          // Memory must have acknowledged the strobe before a low busywait means done.
          if (M_BUSYWAIT) begin
            seen_busy_q <= 1'b1;
          end else if (seen_busy_q) begin
            if (state_q == SERVE_I) i_rdata_q <= M_READDATA;
            else if (!d_wr_q)       d_rdata_q <= M_READDATA;
            last_q      <= grant_q;
            seen_busy_q <= 1'b0;
            state_q     <= RELEASE;
          end
        end
        RELEASE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // A transfer still running after 255 cycles means the memory never answered.
  always @(posedge CLK) begin
    if (!RESET && (state_q == SERVE_I || state_q == SERVE_D))
      assert (serve_cnt_q != 8'hFF);
  end

  always_comb begin
    M_READ      = 1'b0;
    M_WRITE     = 1'b0;
    M_ADDRESS   = '0;
    M_WRITEDATA = '0;
    case (state_q)
      SERVE_I: begin
        M_READ    = I_READ;
        M_ADDRESS = I_ADDRESS;
      end
      SERVE_D: begin
        M_WRITE     = D_WRITE;
        M_READ      = D_READ & ~D_WRITE;
        M_ADDRESS   = D_ADDRESS;
        M_WRITEDATA = D_WRITEDATA;
      end
      default: ;
    endcase
  end

  assign I_BUSYWAIT = i_req & ~((state_q == RELEASE) & ~grant_q);
  assign D_BUSYWAIT = d_req & ~((state_q == RELEASE) &  grant_q);
  assign I_READDATA = i_rdata_q;
  assign D_READDATA = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random request
// mixes, checked against a transfer-level model of the arbitration rules.
module tb_mem_arbiter;
  localparam int AW = 6;
  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          I_READ = 1'b0;
  logic [AW-1:0] I_ADDRESS = '0;
  logic [DW-1:0] I_READDATA;
  logic          I_BUSYWAIT;
  logic          D_READ = 1'b0;
  logic          D_WRITE = 1'b0;
  logic [AW-1:0] D_ADDRESS = '0;
  logic [DW-1:0] D_WRITEDATA = '0;
  logic [DW-1:0] D_READDATA;
  logic          D_BUSYWAIT;
  logic          M_READ;
  logic          M_WRITE;
  logic [AW-1:0] M_ADDRESS;
  logic [DW-1:0] M_WRITEDATA;
  logic [DW-1:0] M_READDATA;
  logic          M_BUSYWAIT;

  always #5 CLK = ~CLK;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .RESET(RESET),
    .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
    .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
    .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
    .M_READ(M_READ), .M_WRITE(M_WRITE), .M_ADDRESS(M_ADDRESS), .M_WRITEDATA(M_WRITEDATA),
    .M_READDATA(M_READDATA), .M_BUSYWAIT(M_BUSYWAIT)
  );

  function automatic logic [31:0] hash(input logic [AW-1:0] a);
    return 32'h9E3779B9 * ({26'd0, a} + 32'd1);
  endfunction

  // Memory model: busy for nbusy edges after a strobe appears, data valid after.
  logic [DW-1:0] mem [64];
  bit            mwr [64];
  int            mcnt;
  int            nbusy = 1;
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mcnt <= 0;
    end else begin
      if (pre_we) begin
        mem[pre_addr] <= pre_data;
        mwr[pre_addr] <= 1'b1;
      end
      if (!(M_READ || M_WRITE)) mcnt <= 0;
      else if (mcnt < nbusy)    mcnt <= mcnt + 1;
      else if (M_WRITE) begin
        mem[M_ADDRESS] <= M_WRITEDATA;
        mwr[M_ADDRESS] <= 1'b1;
      end
    end
  end

  assign M_BUSYWAIT = (M_READ || M_WRITE) && (mcnt < nbusy);
  assign M_READDATA = (M_READ && mcnt >= nbusy) ?
                      (mwr[M_ADDRESS] ? mem[M_ADDRESS] : hash(M_ADDRESS)) : 32'h0BADF00D;

  // Reference state
  int          total = 0;
  int          bad = 0;
  logic [31:0] ref_mem [64];
  logic [31:0] i_rd_exp, d_rd_exp;
  bit          last_m;
  int          i_left, d_left;
  bit          order_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic rand_i();
    I_ADDRESS = AW'($urandom);
  endtask

  task automatic rand_d();
    int op;
    op = $urandom_range(0, 2);
    D_READ      = (op != 1);
    D_WRITE     = (op != 0);
    D_ADDRESS   = AW'($urandom);
    D_WRITEDATA = $urandom;
  endtask

  task automatic do_reset();
    I_READ = 0; D_READ = 0; D_WRITE = 0;
    RESET = 1;
    #1;
    chk("rst_m_read", M_READ, 0);
    chk("rst_m_write", M_WRITE, 0);
    chk("rst_m_addr", M_ADDRESS, 0);
    chk("rst_m_wdata", M_WRITEDATA, 0);
    chk("rst_i_rdata", I_READDATA, 0);
    chk("rst_d_rdata", D_READDATA, 0);
    chk("rst_i_bw", I_BUSYWAIT, 0);
    chk("rst_d_bw", D_BUSYWAIT, 0);
    @(posedge CLK); #1;
    RESET = 0;
    last_m = 0; i_rd_exp = 0; d_rd_exp = 0;
  endtask

  // Runs cycles until every requester has finished its remaining transfers.
  task automatic run(input int maxc);
    int c;
    bit pi, pd, in_run, owner, idle_prev, b2b, just_rel;
    bit i_drop, d_drop, i_raise, d_raise;
    int run_len, gap;
    c = 0; in_run = 0; idle_prev = 1; b2b = 0; gap = 0; run_len = 0; owner = 0;
    i_drop = 0; d_drop = 0; i_raise = 0; d_raise = 0;
    while (i_left > 0 || d_left > 0 || in_run || i_drop || d_drop) begin
      if (c >= maxc) begin
        total++; bad++;
        $error("FAIL run_budget: got=%0d cycles expected=<%0d", c, maxc);
        break;
      end
      pi = I_READ; pd = D_READ | D_WRITE;
      @(posedge CLK); #1; c++;
      just_rel = 0;
      if (M_READ || M_WRITE) begin
        if (!in_run) begin
          in_run = 1; run_len = 0;
          owner = (pi && pd) ? !last_m : pd;
          order_q.push_back(owner);
          if (b2b) chk("b2b_gap", gap <= 1, 1);
        end
        run_len++;
        idle_prev = 0;
        if (!owner) begin
          chk("i_m_read", M_READ, 1);
          chk("i_m_write", M_WRITE, 0);
          chk("i_m_addr", M_ADDRESS, I_ADDRESS);
          chk("i_m_wdata", M_WRITEDATA, 0);
          chk("i_bw_serve", I_BUSYWAIT, 1);
          chk("d_bw_wait", D_BUSYWAIT, D_READ | D_WRITE);
        end else begin
          chk("d_m_write", M_WRITE, D_WRITE);
          chk("d_m_read", M_READ, D_READ & !D_WRITE);
          chk("d_m_addr", M_ADDRESS, D_ADDRESS);
          chk("d_m_wdata", M_WRITEDATA, D_WRITEDATA);
          chk("d_bw_serve", D_BUSYWAIT, 1);
          chk("i_bw_wait", I_BUSYWAIT, I_READ);
        end
        chk("serve_cnt_bound", dut.serve_cnt_q <= 8'(nbusy + 1), 1);
      end else if (in_run) begin
        in_run = 0; just_rel = 1; idle_prev = 0;
        chk("serve_len", run_len, nbusy + 1);
        if (!owner) begin
          chk("i_bw_release", I_BUSYWAIT, 0);
          chk("d_bw_release", D_BUSYWAIT, D_READ | D_WRITE);
          i_rd_exp = ref_mem[I_ADDRESS];
          i_drop = 1;
          b2b = D_READ | D_WRITE;
        end else begin
          chk("d_bw_release", D_BUSYWAIT, 0);
          chk("i_bw_release", I_BUSYWAIT, I_READ);
          if (D_WRITE) ref_mem[D_ADDRESS] = D_WRITEDATA;
          else         d_rd_exp = ref_mem[D_ADDRESS];
          d_drop = 1;
          b2b = I_READ;
        end
        chk("i_rdata", I_READDATA, i_rd_exp);
        chk("d_rdata", D_READDATA, d_rd_exp);
        last_m = owner; gap = 0;
      end else begin
        gap++;
        chk("grant_latency", idle_prev && (pi || pd), 0);
        chk("i_bw_idle", I_BUSYWAIT, I_READ);
        chk("d_bw_idle", D_BUSYWAIT, D_READ | D_WRITE);
        idle_prev = 1;
      end
      if (i_raise) begin rand_i(); I_READ = 1; i_raise = 0; end
      if (d_raise) begin rand_d(); d_raise = 0; end
      if (i_drop && !just_rel) begin
        I_READ = 0; i_drop = 0; i_left--;
        if (i_left > 0) i_raise = 1;
      end
      if (d_drop && !just_rel) begin
        D_READ = 0; D_WRITE = 0; d_drop = 0; d_left--;
        if (d_left > 0) d_raise = 1;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 64; a++) ref_mem[a] = hash(AW'(a));
    do_reset();

    // I-side read of a preloaded block, 5 busy cycles
    pre_addr = 6'h05; pre_data = 32'hDEADBEEF; pre_we = 1;
    @(posedge CLK); #1;
    pre_we = 0; ref_mem[5] = 32'hDEADBEEF;
    nbusy = 5; i_left = 1; d_left = 0;
    I_ADDRESS = 6'h05; I_READ = 1;
    run(100);
    chk("t1_i_rdata", I_READDATA, 32'hDEADBEEF);

    // D-side write-back
    nbusy = 3; i_left = 0; d_left = 1;
    D_ADDRESS = 6'h12; D_WRITEDATA = 32'hA5A5A5A5; D_WRITE = 1; D_READ = 0;
    run(100);
    chk("t2_d_rdata_kept", D_READDATA, 32'h0);

    // Simultaneous arrival after reset: D first
    do_reset();
    order_q.delete();
    nbusy = 4; i_left = 1; d_left = 1;
    rand_i(); I_READ = 1;
    D_ADDRESS = AW'($urandom); D_READ = 1; D_WRITE = 0;
    run(200);
    chk("t3_n", order_q.size(), 2);
    if (order_q.size() == 2) begin
      chk("t3_first_d", order_q[0], 1);
      chk("t3_then_i", order_q[1], 0);
    end

    // Continuous contention alternates D, I, D, I
    order_q.delete();
    nbusy = 2; i_left = 2; d_left = 2;
    rand_i(); I_READ = 1; rand_d();
    run(400);
    chk("t4_n", order_q.size(), 4);
    if (order_q.size() == 4)
      for (int k = 0; k < 4; k++) chk("t4_alt", order_q[k], (k % 2 == 0) ? 1 : 0);

    // Asynchronous reset during the third busy cycle of a D read
    nbusy = 5;
    D_ADDRESS = AW'($urandom); D_READ = 1; D_WRITE = 0;
    @(posedge CLK); #1;
    chk("t5_grant", M_READ, 1);
    @(posedge CLK); @(posedge CLK); #1;
    RESET = 1;
    #1;
    chk("t5_m_read", M_READ, 0);
    chk("t5_m_write", M_WRITE, 0);
    chk("t5_d_rdata", D_READDATA, 0);
    chk("t5_d_bw", D_BUSYWAIT, 1);
    #2;
    RESET = 0;
    last_m = 0; i_rd_exp = 0; d_rd_exp = 0;
    i_left = 0; d_left = 1;
    run(100);

    // Read and write together is a write
    nbusy = 3; i_left = 0; d_left = 1;
    D_ADDRESS = 6'h3F; D_WRITEDATA = $urandom; D_READ = 1; D_WRITE = 1;
    run(100);
    chk("t6_ref_written", ref_mem[63], D_WRITEDATA);

    // Random request mixes
    for (int r = 0; r < 8; r++) begin
      nbusy = $urandom_range(1, 6);
      i_left = $urandom_range(0, 3);
      d_left = $urandom_range(0, 3);
      if (i_left == 0 && d_left == 0) d_left = 1;
      if (i_left > 0) begin rand_i(); I_READ = 1; end
      if (d_left > 0) rand_d();
      run(2000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
